sha3_padder: RTL and testbench
==============================

SHA3_PADDER -- requirements
Module: sha3_padder

Interface
REQ-001 SHALL have parameter RATE_LANES, default 17, meaning 64-bit lanes per rate block (17 = 1088-bit SHA3-256 rate).
REQ-002 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  message word valid.
REQ-005 SHALL have port in_ready  output  1  word accepted when in_valid && in_ready.
REQ-006 SHALL have port in_data  input  64  message bytes, little-endian (byte k = bits 8k+7:8k).
REQ-007 SHALL have port in_bytes  input  4  valid byte count 0..8, honoured only when in_last=1.
REQ-008 SHALL have port in_last  input  1  final word of message.
REQ-009 SHALL have port blk_valid  output  1  padded rate block available.
REQ-010 SHALL have port blk_ready  input  1  consumer (sha3 core) accepts block.
REQ-011 SHALL have port blk_data  output  64*RATE_LANES  rate block, lane 0 in bits 63:0.
REQ-012 SHALL have port blk_last  output  1  block is the final (padded) block of the message.

Function
REQ-013 SHALL use FSM states FILL, EMIT, EXTRA; FILL is the only state with in_ready=1.
REQ-014 SHALL write each accepted word into lane lane_cnt, then increment lane_cnt (0..RATE_LANES-1).
REQ-015 SHALL treat words with in_last=0 as 8 bytes regardless of in_bytes; in_bytes>8 with in_last=1 SHALL be treated as 8.
REQ-016 SHALL zero bytes at and above in_bytes in the last word; lanes after the last word SHALL be zero.
REQ-017 SHALL, on the last word with total block fill < 8*RATE_LANES bytes, XOR 0x06 into byte (8*lane_cnt+in_bytes) and 0x80 into byte 8*RATE_LANES-1 (coinciding -> 0x86), and set blk_last=1.
REQ-018 SHALL, on a non-last word filling lane RATE_LANES-1, go to EMIT with blk_last=0.
REQ-019 SHALL, on a last word exactly filling the block, emit the data block with blk_last=0, then EXTRA: block of 0x06 at byte 0, 0x80 at top byte, blk_last=1.
REQ-020 SHALL assert blk_valid the cycle after the accepting handshake (latency 1); in EXTRA, the cycle after the preceding block's handshake.
REQ-021 SHALL hold blk_data/blk_last stable while blk_valid && !blk_ready.
REQ-022 SHALL, after the final block handshake, clear the buffer and lane_cnt and return to FILL, with in_ready=1 the next cycle.
REQ-023 SHALL accept an empty message (in_last=1, in_bytes=0 at lane 0) as a single pad-only block.

Reset
REQ-024 SHALL, on reset assertion, immediately force in_ready=0, blk_valid=0, blk_last=0, blk_data=0, lane_cnt=0, state FILL; a message in progress SHALL be discarded.
REQ-025 SHALL drive in_ready=1 from the first clock edge after reset deasserts.

Configuration
REQ-026 SHALL, with SHA3_PADDER_SHAKE_EN defined, add input shake_i (1 bit), sampled with the first word of each message; domain byte SHALL be 0x1F when 1, 0x06 when 0.
REQ-027 SHALL, without SHA3_PADDER_SHAKE_EN, omit shake_i and always use domain byte 0x06.

Structure
REQ-028 SHALL take RATE_BITS=1088, LANE_W=64, SHA3_DS=8'h06, SHAKE_DS=8'h1F, PAD_END=8'h80 and the FSM state type from shared package sha3_pkg.
REQ-029 SHALL be a single module with no sub-module; byte masking and pad injection are inline combinational logic.

Verification
REQ-030 SHALL cover empty message -> one block, byte0=0x06, byte135=0x80, all else 0, blk_last=1.
REQ-031 SHALL cover "abc" (in_data=0x636261, in_bytes=3, in_last) -> bytes 0..2=61 62 63, byte3=0x06, byte135=0x80, blk_last=1.
REQ-032 SHALL cover 135-byte message (16 full words + 7-byte last) -> single block, byte135=0x86, blk_last=1.
REQ-033 SHALL cover 136-byte message (17 full words, last in_bytes=8) -> data block blk_last=0, then pad-only block 0x06/0x80 blk_last=1, in_ready=0 throughout both.
REQ-034 SHALL cover blk_ready held low 5 cycles -> blk_data unchanged, in_ready=0, block delivered on 6th cycle.
REQ-035 SHALL cover reset after 5 words -> outputs 0 same cycle; following "abc" message yields exactly the REQ-031 block.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared SHA-3 constants and the padder FSM state type.
package sha3_pkg;

    localparam int RATE_BITS = 1088;
    localparam int LANE_W    = 64;

    localparam logic [7:0] SHA3_DS  = 8'h06;
    localparam logic [7:0] SHAKE_DS = 8'h1F;
    localparam logic [7:0] PAD_END  = 8'h80;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        EMIT  = 2'd1,
        EXTRA = 2'd2
    } pad_state_t;

endpackage

// File: rtl/sha3_padder.sv
// SHA-3 pad10*1 padder: packs 64-bit words into rate blocks.
// Define SHA3_PADDER_SHAKE_EN to add shake_i (0x1F domain byte).
module sha3_padder
    import sha3_pkg::*;
#(
    parameter int RATE_LANES = RATE_BITS / LANE_W
) (
    input  logic                         clk,
    input  logic                         reset,
`ifdef SHA3_PADDER_SHAKE_EN
    input  logic                         shake_i,
`endif
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANE_W-1:0]            in_data,
    input  logic [3:0]                   in_bytes,
    input  logic                         in_last,
    output logic                         blk_valid,
    input  logic                         blk_ready,
    output logic [LANE_W*RATE_LANES-1:0] blk_data,
    output logic                         blk_last
);

    localparam int BW = LANE_W * RATE_LANES;
    localparam int CW = $clog2(RATE_LANES + 1);
    localparam int FW = $clog2(8 * RATE_LANES + 1);

    pad_state_t      state_q, state_d;
    logic [CW-1:0]   lane_q, lane_d;
    logic [BW-1:0]   data_q, data_d;
    logic            last_q, last_d;
    logic            extra_q, extra_d;
    logic            first_q, first_d;
    logic [7:0]      ds_q, ds_d;
    logic            live_q;

    logic [3:0]      nb;
    logic [FW-1:0]   fill;
    logic [63:0]     word;
    logic [7:0]      ds_cur;
    logic [BW-1:0]   pad_tail;
    logic [BW-1:0]   pad_blk;

    // Domain byte is latched from the first word and reused for later blocks.
`ifdef SHA3_PADDER_SHAKE_EN
    assign ds_cur = first_q ? (shake_i ? SHAKE_DS : SHA3_DS) : ds_q;
`else
    assign ds_cur = first_q ? SHA3_DS : ds_q;
`endif

    assign in_ready  = live_q && (state_q == FILL);
    assign blk_valid = (state_q != FILL);
    assign blk_data  = data_q;
    assign blk_last  = last_q;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        data_d  = data_q;
        last_d  = last_q;
        extra_d = extra_q;
        first_d = first_q;
        ds_d    = ds_q;

        nb = (in_last && (in_bytes < 4'd8)) ? in_bytes : 4'd8;
        for (int k = 0; k < 8; k++) begin
            word[8*k +: 8] = (k < int'(nb)) ? in_data[8*k +: 8] : 8'h00;
        end
        fill     = FW'({lane_q, 3'b000}) + FW'(nb);
        pad_tail = BW'(PAD_END) << (BW - 8);
        pad_blk  = (BW'(ds_cur) << (int'(fill) * 8)) ^ pad_tail;

        unique case (state_q)
            FILL: begin
                if (in_valid && in_ready) begin
                    data_d[int'(lane_q)*LANE_W +: LANE_W] = word;
                    first_d = 1'b0;
                    ds_d    = ds_cur;
                    if (in_last) begin
                        first_d = 1'b1;
                        state_d = EMIT;
                        if (fill < FW'(8 * RATE_LANES)) begin
                            data_d = data_d ^ pad_blk;
                            last_d = 1'b1;
                        end else begin
                            // Block exactly full: padding needs its own block.
                            last_d  = 1'b0;
                            extra_d = 1'b1;
                        end
                    end else if (lane_q == CW'(RATE_LANES - 1)) begin
                        last_d  = 1'b0;
                        state_d = EMIT;
                    end else begin
                        lane_d = lane_q + CW'(1);
                    end
                end
            end
            EMIT: begin
                if (blk_ready) begin
                    if (extra_q) begin
                        data_d  = BW'(ds_q) ^ pad_tail;
                        extra_d = 1'b0;
                        last_d  = 1'b1;
                        state_d = EXTRA;
                    end else begin
                        data_d  = '0;
                        lane_d  = '0;
                        last_d  = 1'b0;
                        state_d = FILL;
                    end
                end
            end
            EXTRA: begin
                if (blk_ready) begin
                    data_d  = '0;
                    lane_d  = '0;
                    last_d  = 1'b0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            lane_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            extra_q <= 1'b0;
            first_q <= 1'b1;
            ds_q    <= SHA3_DS;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
            last_q  <= last_d;
            extra_q <= extra_d;
            first_q <= first_d;
            ds_q    <= ds_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sha3_padder.sv
// Randomized bench for sha3_padder against a byte-level pad10*1 model.
module tb_sha3_padder;

    localparam int R   = 17;
    localparam int RB  = 8 * R;
    localparam int BW  = 64 * R;
    localparam int TMO = 1000;

    typedef logic [7:0]    bq_t[$];
    typedef logic [BW-1:0] blk_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic [3:0]    in_bytes;
    logic          in_last;
    logic          blk_valid;
    logic          blk_ready;
    logic [BW-1:0] blk_data;
    logic          blk_last;
    logic          shake = 1'b0;

    int   n_checks = 0;
    int   n_err    = 0;
    blk_t exp_q[$];
    bit   exp_last_q[$];

    always #5 clk = ~clk;

    sha3_padder #(.RATE_LANES(R)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef SHA3_PADDER_SHAKE_EN
        .shake_i   (shake),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bytes  (in_bytes),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: M || ds, zero-fill to a rate multiple, last byte ^= 0x80.
    task automatic model(input bq_t m, input bit shk);
        bq_t  p;
        int   nblk;
        blk_t v;
        p = m;
        p.push_back(shk ? 8'h1F : 8'h06);
        while ((p.size() % RB) != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] ^ 8'h80;
        nblk = p.size() / RB;
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < RB; i++) v[8*i +: 8] = p[b*RB + i];
            exp_q.push_back(v);
            exp_last_q.push_back(b == nblk - 1);
        end
    endtask

    task automatic chk_blk(input string tag, input blk_t e, input bit el);
        check({tag, "_valid"}, 64'(blk_valid), 64'd1);
        check({tag, "_last"}, 64'(blk_last), 64'(el));
        for (int l = 0; l < R; l++)
            check($sformatf("%s_lane%0d", tag, l),
                  blk_data[64*l +: 64], e[64*l +: 64]);
    endtask

    task automatic drive_msg(input bq_t m, input int maxgap);
        int n;
        int nw;
        int vb;
        int t;
        logic [63:0] d;
        n  = m.size();
        nw = (n == 0) ? 1 : (n + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
            in_last = (w == nw - 1);
            vb = in_last ? n - 8 * w : 8;
            d  = {$urandom, $urandom};
            for (int k = 0; k < vb; k++) d[8*k +: 8] = m[8*w + k];
            in_data = d;
            if (!in_last)
                in_bytes = 4'($urandom_range(0, 15));
            else if (vb == 8 && $urandom_range(0, 1) == 1)
                in_bytes = 4'($urandom_range(9, 15));
            else
                in_bytes = 4'(vb);
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < TMO) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                check("in_ready_timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take_blk(input string tag, input int stall);
        blk_t e;
        bit   el;
        int   t;
        e  = exp_q.pop_front();
        el = exp_last_q.pop_front();
        t  = 0;
        while (!blk_valid && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (!blk_valid) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
            return;
        end
        for (int s = 0; s < stall; s++) begin
            chk_blk({tag, "_hold"}, e, el);
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        chk_blk(tag, e, el);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
    endtask

    function automatic bq_t rand_msg(input int n);
        bq_t m;
        for (int i = 0; i < n; i++) m.push_back(8'($urandom));
        return m;
    endfunction

    initial begin
        bq_t m;
        int  n;
        int  nblk;
        int  t;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_bytes  = '0;
        in_last   = 1'b0;
        blk_ready = 1'b0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_blk_valid", 64'(blk_valid), 64'd0);
        check("rst_blk_last", 64'(blk_last), 64'd0);
        check("rst_blk_data", 64'(|blk_data), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Empty message
        m = {};
        model(m, 1'b0);
        drive_msg(m, 0);
        check("empty_latency", 64'(blk_valid), 64'd1);
        check("empty_lane0", blk_data[63:0], 64'h06);
        check("empty_lane16", blk_data[64*16 +: 64], 64'h8000_0000_0000_0000);
        take_blk("empty", 0);
        check("empty_in_ready_after", 64'(in_ready), 64'd1);

        // "abc"
        m = {8'h61, 8'h62, 8'h63};
        model(m, 1'b0);
        drive_msg(m, 0);
        check("abc_latency", 64'(blk_valid), 64'd1);
        check("abc_lane0", blk_data[63:0], 64'h0000_0000_0663_6261);
        take_blk("abc", 0);

        // 135 bytes: pad bytes coincide
        m = rand_msg(135);
        model(m, 1'b0);
        drive_msg(m, 1);
        check("m135_latency", 64'(blk_valid), 64'd1);
        check("m135_top", 64'(blk_data[BW-8 +: 8]), 64'h86);
        take_blk("m135", 0);

        // 136 bytes: data block then pad-only block
        m = rand_msg(136);
        model(m, 1'b0);
        drive_msg(m, 1);
        check("m136_latency", 64'(blk_valid), 64'd1);
        take_blk("m136_data", 0);
        check("m136_extra_latency", 64'(blk_valid), 64'd1);
        check("m136_extra_lane0", blk_data[63:0], 64'h06);
        take_blk("m136_extra", 0);
        check("m136_in_ready_after", 64'(in_ready), 64'd1);

        // Back-pressure for 5 cycles
        m = {8'h61, 8'h62, 8'h63};
        model(m, 1'b0);
        drive_msg(m, 0);
        take_blk("stall", 5);
        check("stall_in_ready_after", 64'(in_ready), 64'd1);

        // Reset in the middle of a message
        for (int i = 0; i < 5; i++) begin
            in_data  = {$urandom, $urandom};
            in_bytes = 4'd8;
            in_last  = 1'b0;
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < TMO) begin
                @(negedge clk);
                t++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_blk_valid", 64'(blk_valid), 64'd0);
        check("midrst_blk_last", 64'(blk_last), 64'd0);
        check("midrst_blk_data", 64'(|blk_data), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready_after", 64'(in_ready), 64'd1);
        m = {8'h61, 8'h62, 8'h63};
        model(m, 1'b0);
        drive_msg(m, 0);
        check("midrst_abc_latency", 64'(blk_valid), 64'd1);
        take_blk("midrst_abc", 0);

        // Random messages across block boundaries
        for (int r = 0; r < 30; r++) begin
            n = (r % 5 == 0) ? RB * $urandom_range(1, 2) - $urandom_range(0, 1)
                             : $urandom_range(0, 300);
            m = rand_msg(n);
`ifdef SHA3_PADDER_SHAKE_EN
            shake = 1'($urandom_range(0, 1));
`endif
            model(m, shake);
            nblk = n / RB + 1;
            fork
                drive_msg(m, 2);
                begin
                    for (int b = 0; b < nblk; b++)
                        take_blk($sformatf("rnd%0d_b%0d", r, b),
                                 $urandom_range(0, 3));
                end
            join
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
